div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Sequencing controller for the shared 32-bit iterative divider core in the riscv-edu CPU.
- Accepts RISC-V M-extension DIV/DIVU/REM/REMU requests from the execute stage.
- Resolves divide-by-zero and signed overflow without starting the core.
- Reuses the previous result for a DIV/REM pair on identical operands.
- Otherwise drives the core unsigned on magnitudes and applies RISC-V sign rules to the quotient and remainder.

Parameters:
- CACHE_EN, 1, enables the last-result reuse path (0 = every normal request runs the core).
- TAG_W, 5, width of the destination-register tag carried through to the response.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_a  in  32  dividend (rs1).
- req_b  in  32  divisor (rs2).
- req_tag  in  TAG_W  destination tag.
- flush  in  1  synchronous pipeline kill.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer takes result.
- resp_data  out  32  quotient or remainder.
- resp_tag  out  TAG_W  tag of the result.
- div_valid  out  1  core run enable; low reloads the core.
- div_dividend  out  32  magnitude of dividend to core.
- div_divisor  out  32  magnitude of divisor to core.
- div_signed  out  1  tied 0; the core always runs unsigned.
- div_ready  in  1  core done; level, held while div_valid high.
- div_q  in  32  core quotient.
- div_r  in  32  core remainder.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE.
  - req_ready=1; resp_valid=0; div_valid=0.
  - resp_data=0, resp_tag=0, div_dividend=0, div_divisor=0.
  - Cache invalid.
- States: IDLE, LOAD, RUN, RESP.
- req_ready = (state==IDLE) && !flush.
- IDLE, on accept:
  - Latch op, a, b, tag.
  - Classify in the same cycle, first match wins:
    - b==0: result q=0xFFFFFFFF, r=a. Go to RESP.
    - signed op, a==0x80000000 and b==0xFFFFFFFF: q=0x80000000, r=0. Go to RESP.
    - CACHE_EN, cache valid, a/b equal to cached operands, signedness (op[0]) equal: take q or r from cache. Go to RESP.
    - Otherwise go to LOAD.
  - Special cases and cache hits: resp_valid high in the cycle after acceptance.
- Magnitudes:
  - mag_a = (signed && a[31]) ? -a : a.
  - mag_b = (signed && b[31]) ? -b : b.
  - All negation is 32-bit two's complement, wrap-around; -0x80000000 = 0x80000000.
- LOAD (1 cycle):
  - div_valid=0.
  - div_dividend/div_divisor hold the registered magnitudes.
  - Core loads on this edge. Next state RUN.
- RUN:
  - div_valid=1; operand outputs stable.
  - When div_ready=1, register results:
    - q = (signed && a[31]^b[31]) ? -div_q : div_q.
    - r = (signed && a[31]) ? -div_r : div_r.
  - Update cache with a, b, signedness, q, r. Go to RESP.
  - div_valid drops to 0 in the RESP cycle.
- Latency with a core that asserts ready after 33 valid-high edges: acceptance edge = edge 0, resp_valid high after edge 35.
- RESP:
  - resp_valid=1; resp_data = op[1] ? r : q; resp_tag = latched tag.
  - Outputs held stable until resp_ready.
  - On resp_valid && resp_ready go to IDLE. A new request is accepted no earlier than the next cycle (no same-cycle turnaround).
- flush (synchronous, any state, highest priority): next state IDLE, resp_valid=0, div_valid=0.
  - Flush in LOAD or RUN also invalidates the cache.
  - Flush in RESP drops the pending result; the cache is kept.
  - Flush in IDLE blocks acceptance that cycle.
- Cache:
  - Updated only by completed core runs; special cases never write it.
  - Stays valid across responses until flush during LOAD/RUN, or reset.
- Reset mid-RUN: div_valid low immediately; the core is reinitialised by div_valid low.

Test Plan:
- DIVU a=100, b=7 -> resp_data=14 after edge 35; then REMU a=100, b=7 -> cache hit, resp_data=2 one cycle after accept, div_valid never rises.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); REM a=7, b=-2 -> 1.
- DIV a=5, b=0 -> 0xFFFFFFFF and REMU a=5, b=0 -> 5, each one cycle after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- resp_ready held 0 for 10 cycles in RESP -> resp_valid, resp_data, resp_tag stable and req_ready=0 throughout; release -> IDLE, next request accepted the following cycle.
- flush at RUN cycle 10 -> div_valid 0 and IDLE next cycle, no response; repeat the same DIV -> full core run (cache was invalidated), correct result.
- rst_n pulsed low mid-RUN (asynchronous, between edges) -> outputs at reset values immediately; after release a DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/div_sequencer.sv
// Sequencer for the shared 32-bit unsigned iterative divider: resolves special cases,
// reuses the last result for matching operands, and applies RISC-V sign rules.
module div_sequencer #(
   parameter bit CACHE_EN = 1'b1,
   parameter int TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             div_valid,
   output logic [31:0]      div_dividend,
   output logic [31:0]      div_divisor,
   output logic             div_signed,
   input  logic             div_ready,
   input  logic [31:0]      div_q,
   input  logic [31:0]      div_r
);

   // state | meaning
   // IDLE  | waiting for a request
   // LOAD  | div_valid low for one cycle so the core reloads its operands
   // RUN   | core iterating, waiting for div_ready
   // RESP  | result held until resp_ready
   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   state_t state, state_nxt;

   logic [1:0]       op_r;
   logic [31:0]      a_r, b_r, q_r, r_r;
   logic [31:0]      mag_a_r, mag_b_r;
   logic [TAG_W-1:0] tag_r;
   logic             cache_valid, cache_op0;
   logic [31:0]      cache_a, cache_b, cache_q, cache_r;

   logic        accept, req_sgn, is_zero, is_ovf, is_hit, sgn_r;
   logic [31:0] q_core, r_core;

   assign req_ready  = (state == IDLE) && !flush;
   assign accept     = req_valid && req_ready;
   assign req_sgn    = !req_op[0];
   assign is_zero    = (req_b == 32'h0);
   assign is_ovf     = req_sgn && (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
   assign is_hit     = CACHE_EN && cache_valid && (req_a == cache_a) && (req_b == cache_b)
                       && (req_op[0] == cache_op0);

   assign sgn_r      = !op_r[0];
   assign q_core     = (sgn_r && (a_r[31] ^ b_r[31])) ? -div_q : div_q;
   assign r_core     = (sgn_r && a_r[31]) ? -div_r : div_r;

   assign resp_valid   = (state == RESP);
   assign resp_data    = op_r[1] ? r_r : q_r;
   assign resp_tag     = tag_r;
   assign div_valid    = (state == RUN);
   assign div_dividend = mag_a_r;
   assign div_divisor  = mag_b_r;
   assign div_signed   = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (is_zero || is_ovf || is_hit) ? RESP : LOAD;
         LOAD: state_nxt = RUN;
         RUN:  if (div_ready) state_nxt = RESP;
         RESP: if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r        <= '0;
         a_r         <= '0;
         b_r         <= '0;
         tag_r       <= '0;
         mag_a_r     <= '0;
         mag_b_r     <= '0;
         q_r         <= '0;
         r_r         <= '0;
         cache_valid <= 1'b0;
         cache_op0   <= 1'b0;
         cache_a     <= '0;
         cache_b     <= '0;
         cache_q     <= '0;
         cache_r     <= '0;
      end else begin
         if (accept) begin
            op_r    <= req_op;
            a_r     <= req_a;
            b_r     <= req_b;
            tag_r   <= req_tag;
            mag_a_r <= (req_sgn && req_a[31]) ? -req_a : req_a;
            mag_b_r <= (req_sgn && req_b[31]) ? -req_b : req_b;
            if (is_zero) begin
               q_r <= 32'hFFFF_FFFF;
               r_r <= req_a;
            end else if (is_ovf) begin
               q_r <= 32'h8000_0000;
               r_r <= 32'h0;
            end else if (is_hit) begin
               q_r <= cache_q;
               r_r <= cache_r;
            end
         end
         if ((state == RUN) && div_ready && !flush) begin
            q_r         <= q_core;
            r_r         <= r_core;
            cache_valid <= 1'b1;
            cache_op0   <= op_r[0];
            cache_a     <= a_r;
            cache_b     <= b_r;
            cache_q     <= q_core;
            cache_r     <= r_core;
         end
         // An aborted run leaves no trustworthy cached pair behind.
         if (flush && ((state == LOAD) || (state == RUN))) cache_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural 33-cycle unsigned divider core.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a, req_b;
   logic [4:0]  req_tag;
   logic        flush;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_tag;
   logic        div_valid, div_signed, div_ready;
   logic [31:0] div_dividend, div_divisor, div_q, div_r;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div_sequencer #(.CACHE_EN(1'b1), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_tag(resp_tag),
      .div_valid(div_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_signed(div_signed), .div_ready(div_ready), .div_q(div_q), .div_r(div_r)
   );

   // Core model: ready after 33 rising edges with div_valid high; div_valid low reloads.
   int core_cnt = 0;
   always @(posedge clk) begin
      if (!div_valid)          core_cnt <= 0;
      else if (core_cnt < 33)  core_cnt <= core_cnt + 1;
   end
   assign div_ready = div_valid && (core_cnt == 33);
   assign div_q = (div_divisor != 0) ? div_dividend / div_divisor : 32'h0;
   assign div_r = (div_divisor != 0) ? div_dividend % div_divisor : 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; request is accepted on the next rising edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Latency = number of edges after the acceptance edge before resp_valid is seen.
   task automatic wait_resp(output int lat, output logic dv_seen);
      @(negedge clk);
      lat = 0;
      dv_seen = div_valid;
      while (!resp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
         dv_seen = dv_seen | div_valid;
      end
   endtask

   task automatic consume(input string name);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk({name, " idle_after"}, {31'h0, req_ready}, 32'h1);
   endtask

   task automatic txn(input string name, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                      input int exp_lat);
      int lat;
      logic dv;
      chk({name, " req_ready"}, {31'h0, req_ready}, 32'h1);
      issue(op, a, b, tag);
      wait_resp(lat, dv);
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " data"}, resp_data, exp);
      chk({name, " tag"}, {27'h0, resp_tag}, {27'h0, tag});
      if (exp_lat == 0) chk({name, " div_valid_seen"}, {31'h0, dv}, 32'h0);
      consume(name);
   endtask

   initial begin
      int lat;
      logic dv, bad;
      rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
      flush = 1'b0; resp_ready = 1'b0;
      #1;
      chk("rst req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst div_valid", {31'h0, div_valid}, 32'h0);
      chk("rst resp_data", resp_data, 32'h0);
      chk("rst dividend", div_dividend, 32'h0);
      chk("rst div_signed", {31'h0, div_signed}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      txn("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 35);
      txn("remu_hit", 2'b11, 32'd100, 32'd7, 5'd4, 32'd2, 0);
      txn("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 35);
      txn("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 0);
      txn("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 35);
      txn("div_by0", 2'b00, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 0);
      txn("remu_by0", 2'b11, 32'd5, 32'd0, 5'd9, 32'd5, 0);
      txn("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 0);
      txn("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0, 0);

      // Backpressure: response must hold while resp_ready stays low.
      issue(2'b01, 32'd100, 32'd7, 5'd12);
      wait_resp(lat, dv);
      chk("stall latency", lat, 35);
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (!resp_valid || resp_data !== 32'd14 || resp_tag !== 5'd12 || req_ready) bad = 1'b1;
      end
      chk("stall stable", {31'h0, bad}, 32'h0);
      consume("stall");
      txn("after_stall", 2'b00, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 0);

      // Flush mid-run drops the request and invalidates the cache.
      txn("fill_cache", 2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd14, 32'hFFFF_FEB3, 35);
      issue(2'b00, 32'd50, 32'd5, 5'd15);
      repeat (10) @(negedge clk);
      chk("flush pre div_valid", {31'h0, div_valid}, 32'h1);
      flush = 1'b1;
      #1;
      chk("flush req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush div_valid", {31'h0, div_valid}, 32'h0);
      chk("flush req_ready_after", {31'h0, req_ready}, 32'h1);
      bad = 1'b0;
      repeat (40) begin
         if (resp_valid) bad = 1'b1;
         @(negedge clk);
      end
      chk("flush no_resp", {31'h0, bad}, 32'h0);
      txn("refill_div", 2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd16, 32'hFFFF_FEB3, 35);
      txn("rerun_div", 2'b00, 32'd50, 32'd5, 5'd17, 32'd10, 35);

      // Asynchronous reset in the middle of a run.
      issue(2'b01, 32'd9, 32'd3, 5'd18);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst div_valid", {31'h0, div_valid}, 32'h0);
      chk("arst req_ready", {31'h0, req_ready}, 32'h1);
      chk("arst resp_tag", {27'h0, resp_tag}, 32'h0);
      chk("arst divisor", div_divisor, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txn("divu_max", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd19, 32'hFFFF_FFFF, 35);

      // Flush in RESP drops only the pending result; the cache survives.
      issue(2'b11, 32'hFFFF_FFFF, 32'd1, 5'd20);
      wait_resp(lat, dv);
      chk("resp_flush latency", lat, 0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("resp_flush resp_valid", {31'h0, resp_valid}, 32'h0);
      txn("cache_kept", 2'b11, 32'hFFFF_FFFF, 32'd1, 5'd21, 32'h0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
